// File: rtl/ifu_bus_ctrl_pkg.sv
// Shared widths and helpers for the instruction-side bus controller.
package ifu_bus_ctrl_pkg;
  localparam int IFU_ADDR_W   = 32;
  localparam int IFU_INSTR_W  = 32;
  localparam int IBUS_RESP_W  = IFU_INSTR_W + 1;
  localparam int IFU_MAX_OUTS = 2;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction
endpackage

// File: rtl/ifu_req_tracker.sv
// In-order FIFO of outstanding fetch addresses with per-entry stale marking.
module ifu_req_tracker #(
  parameter int AW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [AW-1:0]                 push_addr,
  input  logic                          pop,
  input  logic [AW-1:0]                 pc,
  output logic [AW-1:0]                 head_addr,
  output logic                          head_stale,
  output logic [DEPTH-1:0]              match_vec,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]         stale_q, stale_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     pop_ok, push_ok;

  assign count      = count_q;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_stale = stale_q[rd_ptr_q];

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      match_vec[i] = valid_q[i] && !stale_q[i] && (addr_q[i] == pc);
  end

  always_comb begin
    addr_d   = addr_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    // Sticky: an entry that ever disagreed with pc can never deliver.
    for (int i = 0; i < DEPTH; i++)
      stale_d[i] = stale_q[i] | (addr_q[i] != pc);
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      addr_d[wr_ptr_q]  = push_addr;
      stale_d[wr_ptr_q] = 1'b0;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      stale_q  <= '0;
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      stale_q  <= stale_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop_ok));
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));
endmodule

// File: rtl/ifu_bus_ctrl.sv
// Fetch-side bus controller: issues word reads for pc, filters stale responses,
// and replays the last delivered word while pc is held.
module ifu_bus_ctrl
  import ifu_bus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = IFU_ADDR_W,
  parameter int INSTR_WIDTH     = IFU_INSTR_W,
  parameter int MAX_OUTSTANDING = IFU_MAX_OUTS
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   instr_read_data_valid,
  output logic [INSTR_WIDTH-1:0] instr_read_data,
  output logic                   instr_access_fault,
  output logic                   ibus_req,
  output logic [ADDR_WIDTH-1:0]  ibus_addr,
  input  logic                   ibus_gnt,
  input  logic                   ibus_rvalid,
  input  logic [INSTR_WIDTH-1:0] ibus_rdata,
  input  logic                   ibus_rerr
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [ADDR_WIDTH-1:0]      trk_head_addr;
  logic                       trk_head_stale, trk_full, trk_empty;
  logic [MAX_OUTSTANDING-1:0] trk_match;
  logic [CNT_W-1:0]           trk_count;

  logic                   hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0]  hold_addr_q, hold_addr_d;
  logic [INSTR_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                   hold_err_q, hold_err_d;

  logic hold_hit, resp_hit, room, issue;

  ifu_req_tracker #(.AW(ADDR_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_trk (
    .clk        (cpu_clk),
    .rst        (cpu_rst),
    .push       (ibus_req && ibus_gnt),
    .push_addr  (pc),
    .pop        (ibus_rvalid),
    .pc         (pc),
    .head_addr  (trk_head_addr),
    .head_stale (trk_head_stale),
    .match_vec  (trk_match),
    .count      (trk_count),
    .full       (trk_full),
    .empty      (trk_empty)
  );

  always_comb begin
    hold_hit = hold_valid_q && (hold_addr_q == pc);
    resp_hit = ibus_rvalid && !trk_empty && !trk_head_stale && (trk_head_addr == pc);
    // A response popping the head this cycle frees the slot for a same-cycle push.
    room     = !trk_full || (ibus_rvalid && !trk_empty);
    issue    = !cpu_rst && word_aligned(pc[1:0]) && !hold_hit && !(|trk_match) && room;

    ibus_req  = issue;
    ibus_addr = issue ? pc : '0;

    instr_read_data_valid = !cpu_rst && (hold_hit || resp_hit);
    instr_read_data       = '0;
    instr_access_fault    = 1'b0;
    if (instr_read_data_valid) begin
      instr_read_data    = resp_hit ? ibus_rdata : hold_data_q;
      instr_access_fault = resp_hit ? ibus_rerr  : hold_err_q;
    end

    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    hold_err_d   = hold_err_q;
    if (resp_hit) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = pc;
      hold_data_d  = ibus_rdata;
      hold_err_d   = ibus_rerr;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_err_q   <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      hold_err_q   <= hold_err_d;
    end
  end

  a_rvalid_needs_entry: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    !(ibus_rvalid && trk_empty));
endmodule
